peripheral_apb4_responder: RTL and testbench
============================================

Name: peripheral_apb4_responder

Overview:
- APB4 (AMBA4 APB) completer/slave. It is the responder end of the APB4 initiator bus-functional model.
- Provides a byte-strobed register memory with programmable wait states, PSLVERR on out-of-range addresses, and protocol-violation detection.
- Sits on the APB4 bus as the generic target used by the MPSoC peripheral benches.
- Fully synthesizable.

Parameters:
- PADDR_SIZE, 4, APB address width in bits.
- PDATA_SIZE, 8, APB data width in bits. Must be a multiple of 8, and PDATA_SIZE/8 must be a power of 2.
- MEM_DEPTH, 12, number of implemented words. Must be ≤ 2^(PADDR_SIZE-ALIGN), where ALIGN = log2(PDATA_SIZE/8).

Ports:
- PCLK  in  1  bus clock; all state updates on rising edge.
- PRESETn  in  1  asynchronous active-low reset.
- PSEL  in  1  select.
- PENABLE  in  1  access phase.
- PADDR  in  PADDR_SIZE  byte address.
- PWRITE  in  1  1=write, 0=read.
- PSTRB  in  PDATA_SIZE/8  write byte lanes.
- PWDATA  in  PDATA_SIZE  write data.
- PRDATA  out  PDATA_SIZE  read data.
- PREADY  out  1  transfer complete.
- PSLVERR  out  1  error response.
- wait_cycles_i  in  4  wait states inserted per transfer; sampled at setup.
- proto_err_o  out  1  one-cycle pulse on APB protocol violation.

Behaviour:
- Interface (already decided): single clock PCLK; PRESETn is asynchronous, active-low.
- Reset values: PRDATA=0, PREADY=0, PSLVERR=0, proto_err_o=0, all memory words=0, FSM=IDLE, wait counter=0.
- Word index = PADDR[PADDR_SIZE-1:ALIGN]. Low ALIGN address bits are ignored. Index ≥ MEM_DEPTH is out of range.
- FSM states:
  - IDLE: on PSEL=1 & PENABLE=0 (setup phase), latch addr, PWRITE, PWDATA, PSTRB; load cnt=wait_cycles_i; go to ACCESS. PSEL=1 & PENABLE=1 while in IDLE pulses proto_err_o and stays in IDLE.
  - ACCESS: expects PSEL=1 & PENABLE=1 with address/control equal to the latched values.
    - cnt>0: decrement, PREADY=0.
    - cnt==0: PREADY=1 (combinational from registered state/cnt), so the zero-wait response lands in the first access cycle.
    - On the completing edge (PREADY=1): write (if any) commits, then go to IDLE.
- Back-to-back transfers: the cycle after completion may be a new setup phase; IDLE accepts it with no bubble.
- Latency: transfer = 1 setup cycle + (wait_cycles_i + 1) access cycles.
- Write completion: for each lane i with PSTRB[i]=1, byte i of mem[idx] = PWDATA byte i; other lanes unchanged. PSTRB=0 is a legal no-op write with PSLVERR=0.
- Read data: PRDATA = mem[idx] only while PREADY=1 & !PWRITE; otherwise 0. PSTRB is ignored on reads.
- Out of range: PSLVERR=1 together with PREADY=1; write suppressed; PRDATA=0. PSLVERR is 0 whenever PREADY=0.
- Protocol violations in ACCESS:
  - PSEL=0, PENABLE=0, or PADDR/PWRITE changed: pulse proto_err_o, abort to IDLE, no write, PREADY stays 0.
  - If that same cycle is a valid setup (PSEL=1 & PENABLE=0), it is accepted as a new transfer.
- Reset mid-transfer: immediate return to the reset values above; no partial write.
- wait_cycles_i changes during ACCESS have no effect on the current transfer.

Optional Feature:
- Macro: APB4_RESPONDER_PPROT_EN.
- Defined:
  - Adds input PPROT [2:0], latched at setup.
  - Words with index ≥ MEM_DEPTH/2 are privileged. Access with PPROT[0]=0 gets PSLVERR=1, write suppressed, PRDATA=0.
  - Timing is unchanged.
- Undefined: no PPROT port; all in-range words are accessible.

Decomposition:
- Package peripheral_apb4_responder_pkg:
  - FSM state enum (IDLE, ACCESS).
  - Wait-counter width constant (4).
  - ALIGN computation function (clog2 of PDATA_SIZE/8).
- Sub-module peripheral_apb4_responder_mem:
  - MEM_DEPTH x PDATA_SIZE storage with async-reset clear, byte-strobed write port and combinational read port.
  - The top-level FSM drives it.

Test Plan:
- Reset, then write PADDR=3, PWDATA=0xA5, PSTRB=1, wait=0; read PADDR=3 → PREADY in first access cycle, PRDATA=0xA5, PSLVERR=0.
- wait=3, read PADDR=3 → PREADY low for 3 access cycles, high on the 4th with PRDATA=0xA5.
- Write PADDR=13 (≥12), PWDATA=0x5A → PREADY=1 & PSLVERR=1; subsequent read of PADDR=13 → PSLVERR=1, PRDATA=0.
- Write PADDR=2, PWDATA=0x77, PSTRB=0 → PSLVERR=0; read PADDR=2 → 0x00.
- wait=2: drop PSEL in the second access cycle → proto_err_o pulses 1 cycle, no write. Back-to-back write to PADDR=4 then read of PADDR=4 → 0x xx matches the written value with zero idle cycles.
- Assert PRESETn=0 during a wait=5 write to PADDR=1 → all outputs 0; read PADDR=1 after reset → 0x00.

Source files
------------

// File: rtl/peripheral_apb4_responder_pkg.sv
// -----------------------------------------------------------------------------
// peripheral_apb4_responder_pkg
// Shared types and constants for the APB4 responder:
//   state_t    - transfer FSM state (IDLE, ACCESS)
//   CNT_W      - width of the wait-state counter
//   calc_align - number of ignored low address bits for a given data width
// Optional feature macro used by the design: APB4_RESPONDER_PPROT_EN
// -----------------------------------------------------------------------------
package peripheral_apb4_responder_pkg;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  localparam int CNT_W = 4;

  // Byte-offset bits inside one data word: clog2(PDATA_SIZE/8).
  function automatic int calc_align(input int pdata_size);
    return $clog2(pdata_size / 8);
  endfunction

endpackage

// File: rtl/peripheral_apb4_responder_mem.sv
// -----------------------------------------------------------------------------
// peripheral_apb4_responder_mem
// DEPTH x DATA_W register storage, cleared by the asynchronous reset.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (clears every word)
//   we         : write enable (caller guarantees idx is in range)
//   idx        : word index shared by the write and read ports
//   strb       : per-byte write lane enables
//   wdata      : write data
//   rdata      : combinational read data, 0 for an out-of-range index
// -----------------------------------------------------------------------------
module peripheral_apb4_responder_mem #(
  parameter int DEPTH  = 12,
  parameter int DATA_W = 8,
  parameter int IDX_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [IDX_W-1:0]      idx,
  input  logic [DATA_W/8-1:0]   strb,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     rdata
);

  localparam int               AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [IDX_W:0]   DEPTH_L = (IDX_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [AW-1:0]     addr_s;
  logic              in_range_s;

  // Index decode: only the bits needed to address DEPTH words.
  always_comb begin
    addr_s     = idx[AW-1:0];
    in_range_s = ({1'b0, idx} < DEPTH_L);
  end

  // Storage: async clear, byte-lane write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (we) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (strb[b]) begin
          mem_r[addr_s][b*8 +: 8] <= wdata[b*8 +: 8];
        end
      end
    end
  end

  // Read port: out-of-range indices read as zero.
  always_comb begin
    if (in_range_s) begin
      rdata = mem_r[addr_s];
    end else begin
      rdata = '0;
    end
  end

endmodule

// File: rtl/peripheral_apb4_responder.sv
// -----------------------------------------------------------------------------
// peripheral_apb4_responder
// APB4 completer with a byte-strobed register memory, programmable wait
// states, PSLVERR on out-of-range words and protocol-violation detection.
// Ports:
//   PCLK, PRESETn         : bus clock, asynchronous active-low reset
//   PSEL, PENABLE, PADDR,
//   PWRITE, PSTRB, PWDATA : APB4 request
//   PRDATA, PREADY,
//   PSLVERR               : APB4 response
//   wait_cycles_i         : wait states for the next transfer, sampled at setup
//   proto_err_o           : one-cycle pulse after a protocol violation
//   PPROT                 : protection bits (only with APB4_RESPONDER_PPROT_EN)
// Optional feature macro: APB4_RESPONDER_PPROT_EN - upper half of the memory
// becomes privileged; PPROT[0]=0 accesses there get PSLVERR.
// -----------------------------------------------------------------------------
module peripheral_apb4_responder
  import peripheral_apb4_responder_pkg::*;
#(
  parameter int PADDR_SIZE = 4,
  parameter int PDATA_SIZE = 8,
  parameter int MEM_DEPTH  = 12
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
`ifdef APB4_RESPONDER_PPROT_EN
  input  logic [2:0]              PPROT,
`endif
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [CNT_W-1:0]        wait_cycles_i,
  output logic                    proto_err_o
);

  localparam int             ALIGN   = calc_align(PDATA_SIZE);
  localparam int             IDX_W   = PADDR_SIZE - ALIGN;
  localparam logic [IDX_W:0] DEPTH_L = (IDX_W + 1)'(MEM_DEPTH);

  state_t                  state_r, state_s;
  logic [CNT_W-1:0]        cnt_r, cnt_s;
  logic [PADDR_SIZE-1:0]   addr_r;
  logic                    pwrite_r;
  logic [PDATA_SIZE-1:0]   wdata_r;
  logic [PDATA_SIZE/8-1:0] strb_r;
  logic                    proto_err_r, proto_err_s;
  logic                    latch_s;
  logic                    setup_s;
  logic                    viol_s;
  logic                    ready_s;
  logic                    err_s;
  logic                    priv_err_s;
  logic                    we_s;
  logic [IDX_W-1:0]        idx_s;
  logic [PDATA_SIZE-1:0]   rdata_s;

`ifdef APB4_RESPONDER_PPROT_EN
  localparam logic [IDX_W:0] PRIV_L = (IDX_W + 1)'(MEM_DEPTH / 2);
  logic [2:0] pprot_r;
`endif

  // Transfer decode from latched request and live bus inputs.
  always_comb begin
    idx_s   = addr_r[PADDR_SIZE-1:ALIGN];
    setup_s = PSEL && !PENABLE;
    // Any departure from a stable access phase aborts the transfer.
    viol_s  = (state_r == ACCESS) &&
              (!PSEL || !PENABLE || (PADDR != addr_r) || (PWRITE != pwrite_r));
`ifdef APB4_RESPONDER_PPROT_EN
    priv_err_s = ({1'b0, idx_s} >= PRIV_L) && !pprot_r[0];
`else
    priv_err_s = 1'b0;
`endif
    err_s   = ({1'b0, idx_s} >= DEPTH_L) || priv_err_s;
    ready_s = (state_r == ACCESS) && (cnt_r == '0) && !viol_s;
    we_s    = ready_s && pwrite_r && !err_s;
  end

  // Response outputs: data and error are only visible in the completing cycle.
  always_comb begin
    PREADY      = ready_s;
    PSLVERR     = ready_s && err_s;
    proto_err_o = proto_err_r;
    if (ready_s && !pwrite_r && !err_s) begin
      PRDATA = rdata_s;
    end else begin
      PRDATA = '0;
    end
  end

  // FSM next state, wait counter and request-latch control.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    latch_s     = 1'b0;
    proto_err_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (setup_s) begin
          latch_s = 1'b1;
          cnt_s   = wait_cycles_i;
          state_s = ACCESS;
        end else if (PSEL && PENABLE) begin
          proto_err_s = 1'b1;
          state_s     = IDLE;
        end else begin
          state_s = IDLE;
        end
      end
      ACCESS: begin
        if (viol_s) begin
          proto_err_s = 1'b1;
          // A fresh setup phase in the violating cycle is still honoured.
          if (setup_s) begin
            latch_s = 1'b1;
            cnt_s   = wait_cycles_i;
            state_s = ACCESS;
          end else begin
            state_s = IDLE;
          end
        end else if (cnt_r != '0) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // FSM, counter and violation-pulse registers.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_r     <= IDLE;
      cnt_r       <= '0;
      proto_err_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      proto_err_r <= proto_err_s;
    end
  end

  // Request latch captured at setup.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      addr_r   <= '0;
      pwrite_r <= 1'b0;
      wdata_r  <= '0;
      strb_r   <= '0;
`ifdef APB4_RESPONDER_PPROT_EN
      pprot_r  <= 3'b000;
`endif
    end else if (latch_s) begin
      addr_r   <= PADDR;
      pwrite_r <= PWRITE;
      wdata_r  <= PWDATA;
      strb_r   <= PSTRB;
`ifdef APB4_RESPONDER_PPROT_EN
      pprot_r  <= PPROT;
`endif
    end else begin
      addr_r   <= addr_r;
      pwrite_r <= pwrite_r;
      wdata_r  <= wdata_r;
      strb_r   <= strb_r;
`ifdef APB4_RESPONDER_PPROT_EN
      pprot_r  <= pprot_r;
`endif
    end
  end

  peripheral_apb4_responder_mem #(
    .DEPTH  (MEM_DEPTH),
    .DATA_W (PDATA_SIZE),
    .IDX_W  (IDX_W)
  ) u_mem (
    .clk   (PCLK),
    .rst_n (PRESETn),
    .we    (we_s),
    .idx   (idx_s),
    .strb  (strb_r),
    .wdata (wdata_r),
    .rdata (rdata_s)
  );

endmodule

// File: tb/tb_peripheral_apb4_responder.sv
module tb_peripheral_apb4_responder;

  logic       PCLK;
  logic       PRESETn;
  logic       PSEL;
  logic       PENABLE;
  logic [3:0] PADDR;
  logic       PWRITE;
  logic [0:0] PSTRB;
  logic [7:0] PWDATA;
  logic [7:0] PRDATA;
  logic       PREADY;
  logic       PSLVERR;
  logic [3:0] wait_cycles_i;
  logic       proto_err_o;
`ifdef APB4_RESPONDER_PPROT_EN
  logic [2:0] PPROT;
`endif

  int checks;
  int failures;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;
  exp_t sb_q[$];

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic       strb;
    logic [3:0] w;
    logic [7:0] exp_rd;
    logic       exp_err;
  } vec_t;
  vec_t vt[14];

  peripheral_apb4_responder dut (
    .PCLK          (PCLK),
    .PRESETn       (PRESETn),
`ifdef APB4_RESPONDER_PPROT_EN
    .PPROT         (PPROT),
`endif
    .PSEL          (PSEL),
    .PENABLE       (PENABLE),
    .PADDR         (PADDR),
    .PWRITE        (PWRITE),
    .PSTRB         (PSTRB),
    .PWDATA        (PWDATA),
    .PRDATA        (PRDATA),
    .PREADY        (PREADY),
    .PSLVERR       (PSLVERR),
    .wait_cycles_i (wait_cycles_i),
    .proto_err_o   (proto_err_o)
  );

  initial PCLK = 1'b0;
  always #5 PCLK = ~PCLK;

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench did not finish");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic [7:0] rd, input logic err, input int lat);
    exp_t e;
    e.rdata = rd;
    e.err   = err;
    e.lat   = lat;
    sb_q.push_back(e);
  endtask

  // Starts right after a rising edge; returns right after the edge that follows
  // completion with the bus idle, so consecutive calls are back-to-back.
  task automatic xfer(input logic wr, input logic [3:0] a, input logic [7:0] d,
                      input logic s, input logic [3:0] w, input string nm);
    exp_t e;
    int   n;
    logic done;
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = a;
    PWDATA = d; PSTRB = s; wait_cycles_i = w;
    @(negedge PCLK);
    chk({nm, ".setup_ready"}, {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    wait_cycles_i = 4'hF;
    n = 0;
    done = 1'b0;
    while (!done && n <= 20) begin
      @(negedge PCLK);
      if (PREADY) begin
        done = 1'b1;
      end else begin
        chk({nm, ".wait_resp"}, {23'd0, PSLVERR, PRDATA}, 32'd0);
        n++;
        @(posedge PCLK); #1;
      end
    end
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL %s.timeout actual=no_PREADY required=PREADY", nm);
    end else if (sb_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s.scoreboard actual=empty required=entry", nm);
    end else begin
      e = sb_q.pop_front();
      chk({nm, ".latency"}, n, e.lat);
      chk({nm, ".prdata"}, {24'd0, PRDATA}, {24'd0, e.rdata});
      chk({nm, ".pslverr"}, {31'd0, PSLVERR}, {31'd0, e.err});
    end
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    PRESETn = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PADDR = 4'd0; PWRITE = 1'b0;
    PSTRB = 1'b0; PWDATA = 8'd0; wait_cycles_i = 4'd0;
`ifdef APB4_RESPONDER_PPROT_EN
    PPROT = 3'b001;
`endif

    //        wr    addr   data   strb  wait   exp_rd exp_err
    vt[0]  = '{1'b1, 4'd3,  8'hA5, 1'b1, 4'd0, 8'h00, 1'b0};
    vt[1]  = '{1'b0, 4'd3,  8'h00, 1'b0, 4'd0, 8'hA5, 1'b0};
    vt[2]  = '{1'b0, 4'd3,  8'h00, 1'b1, 4'd3, 8'hA5, 1'b0};
    vt[3]  = '{1'b1, 4'd13, 8'h5A, 1'b1, 4'd0, 8'h00, 1'b1};
    vt[4]  = '{1'b0, 4'd13, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1};
    vt[5]  = '{1'b1, 4'd2,  8'h77, 1'b0, 4'd0, 8'h00, 1'b0};
    vt[6]  = '{1'b0, 4'd2,  8'h00, 1'b0, 4'd0, 8'h00, 1'b0};
    vt[7]  = '{1'b1, 4'd4,  8'h3C, 1'b1, 4'd1, 8'h00, 1'b0};
    vt[8]  = '{1'b0, 4'd4,  8'h00, 1'b0, 4'd0, 8'h3C, 1'b0};
    vt[9]  = '{1'b1, 4'd11, 8'hFF, 1'b1, 4'd0, 8'h00, 1'b0};
    vt[10] = '{1'b0, 4'd11, 8'h00, 1'b0, 4'd2, 8'hFF, 1'b0};
    vt[11] = '{1'b0, 4'd12, 8'h00, 1'b0, 4'd0, 8'h00, 1'b1};
    vt[12] = '{1'b1, 4'd0,  8'h12, 1'b1, 4'd2, 8'h00, 1'b0};
    vt[13] = '{1'b0, 4'd0,  8'h00, 1'b0, 4'd0, 8'h12, 1'b0};

    repeat (3) @(posedge PCLK);
    #1;
    PRESETn = 1'b1;
    @(negedge PCLK);
    chk("reset.prdata", {24'd0, PRDATA}, 32'd0);
    chk("reset.pready", {31'd0, PREADY}, 32'd0);
    chk("reset.pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("reset.proto_err", {31'd0, proto_err_o}, 32'd0);
    @(posedge PCLK); #1;

    for (int i = 0; i < 14; i++) begin
      push_exp(vt[i].exp_rd, vt[i].exp_err, int'(vt[i].w));
      xfer(vt[i].wr, vt[i].addr, vt[i].data, vt[i].strb, vt[i].w, $sformatf("vec%0d", i));
    end

    // PSEL dropped in the second access cycle of a wait=2 write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd5;
    PWDATA = 8'h99; PSTRB = 1'b1; wait_cycles_i = 4'd2;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("abort.pready", {31'd0, PREADY}, 32'd0);
    chk("abort.pulse_early", {31'd0, proto_err_o}, 32'd0);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("abort.pulse", {31'd0, proto_err_o}, 32'd1);
    @(posedge PCLK); #1;
    @(negedge PCLK);
    chk("abort.pulse_end", {31'd0, proto_err_o}, 32'd0);
    @(posedge PCLK); #1;

    // Access phase without a setup phase while idle.
    PSEL = 1'b1; PENABLE = 1'b1; PWRITE = 1'b0; PADDR = 4'd0;
    @(negedge PCLK);
    chk("idle_viol.pready", {31'd0, PREADY}, 32'd0);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    @(negedge PCLK);
    chk("idle_viol.pulse", {31'd0, proto_err_o}, 32'd1);
    @(posedge PCLK); #1;
    push_exp(8'h00, 1'b0, 0);
    xfer(1'b0, 4'd5, 8'h00, 1'b0, 4'd0, "abort.no_write");

    // New setup phase in the middle of an access: old transfer dropped, new one taken.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd7;
    PWDATA = 8'h44; PSTRB = 1'b1; wait_cycles_i = 4'd1;
    @(posedge PCLK); #1;
    PADDR = 4'd8; PWDATA = 8'h55; wait_cycles_i = 4'd0;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    @(negedge PCLK);
    chk("resetup.pready", {31'd0, PREADY}, 32'd1);
    chk("resetup.pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("resetup.pulse", {31'd0, proto_err_o}, 32'd1);
    @(posedge PCLK); #1;
    PSEL = 1'b0; PENABLE = 1'b0;
    push_exp(8'h00, 1'b0, 0);
    xfer(1'b0, 4'd7, 8'h00, 1'b0, 4'd0, "resetup.old");
    push_exp(8'h55, 1'b0, 0);
    xfer(1'b0, 4'd8, 8'h00, 1'b0, 4'd0, "resetup.new");

    // Reset in the middle of a wait=5 write.
    PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 4'd1;
    PWDATA = 8'hEE; PSTRB = 1'b1; wait_cycles_i = 4'd5;
    @(posedge PCLK); #1;
    PENABLE = 1'b1;
    repeat (2) @(posedge PCLK);
    @(negedge PCLK);
    #1;
    PRESETn = 1'b0;
    #1;
    chk("midreset.prdata", {24'd0, PRDATA}, 32'd0);
    chk("midreset.pready", {31'd0, PREADY}, 32'd0);
    chk("midreset.pslverr", {31'd0, PSLVERR}, 32'd0);
    chk("midreset.proto_err", {31'd0, proto_err_o}, 32'd0);
    PSEL = 1'b0; PENABLE = 1'b0;
    @(posedge PCLK); #1;
    PRESETn = 1'b1;
    @(posedge PCLK); #1;
    push_exp(8'h00, 1'b0, 0);
    xfer(1'b0, 4'd1, 8'h00, 1'b0, 4'd0, "midreset.addr1");
    push_exp(8'h00, 1'b0, 0);
    xfer(1'b0, 4'd3, 8'h00, 1'b0, 4'd0, "midreset.addr3_cleared");
    push_exp(8'h00, 1'b0, 1);
    xfer(1'b0, 4'd11, 8'h00, 1'b0, 4'd1, "midreset.addr11_cleared");

    chk("scoreboard.drained", sb_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
